mc10_exp_ram: RTL
=================

MC10_EXP_RAM -- requirements
Module: mc10_exp_ram

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 16'h5000, meaning the first byte of the expansion window (aligned to 4 KB).
REQ-002 SHALL have parameter SIZE_KB, default 16, meaning the window and internal RAM size; legal values are 4, 8 and 16.
REQ-003 SHALL have parameter RST_CYCLES, default 16'd50000, meaning the length of the reset pulse in clk_sys cycles.
REQ-004 SHALL have parameter DEB_CYCLES, default 16'd10000, meaning the NMI button debounce period in clk_sys cycles.
REQ-005 Port clk_sys, input, 1 bit: the single clock; all logic SHALL be clocked on its rising edge.
REQ-006 Port reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-007 Port exp_out, input, 18 bits: {R/W, A15-A0, E} from the CPU side, with E asynchronous to clk_sys.
REQ-008 Port cpu_dout, input, 8 bits: CPU write data, valid while E is high.
REQ-009 Port enable, input, 1 bit: enables the RAM pack; when 0, sel and D SHALL be 0.
REQ-010 Port btn_reset, input, 1 bit: reset request from the user, asynchronous.
REQ-011 Port btn_nmi, input, 1 bit: NMI button, asynchronous and bouncy.
REQ-012 Port exp_in, output, 11 bits: {D7-D0, sel, reset, nmi}.

Function
REQ-013 SHALL pass E, btn_reset and btn_nmi each through a 2-flop synchroniser, and SHALL derive e_rise and e_fall from the synchronised E.
REQ-014 hit SHALL be true when enable=1 and BASE_ADDR <= A < BASE_ADDR + SIZE_KB*1024, using unsigned 16-bit compare and no wrap past FFFF.
REQ-015 sel (exp_in[2]) SHALL be a registered copy of hit with 1 clk_sys latency, updated every cycle and independent of E.
REQ-016 SHALL implement an FSM with states IDLE, RD, RDHOLD and WR.
REQ-017 IDLE: on e_rise with hit and R/W=1, SHALL latch A and go to RD; on e_rise with hit and R/W=0, SHALL latch A and go to WR; otherwise SHALL stay in IDLE.
REQ-018 RD: SHALL issue a RAM read at the latched offset; read data SHALL be registered into D in the next cycle, then the FSM SHALL go to RDHOLD.
REQ-019 RDHOLD: SHALL hold D stable until e_fall, then clear D to 8'h00 on the following cycle and return to IDLE.
REQ-020 D SHALL be 8'h00 in every state except RDHOLD, so the output can be wire-ORed onto the CPU data bus.
REQ-021 WR: on e_fall, SHALL write cpu_dout (sampled one cycle before e_fall) into RAM at the latched offset for exactly one cycle, then return to IDLE.
REQ-022 RAM offset SHALL be A - BASE_ADDR, truncated to log2(SIZE_KB*1024) bits; RAM SHALL be single-port, inferred as block RAM, and hold SIZE_KB*1024 x 8 bits.
REQ-023 If enable drops during RD, RDHOLD or WR, the FSM SHALL return to IDLE next cycle with D=0 and no RAM write.
REQ-024 If e_rise arrives while not in IDLE (a missed e_fall), the FSM SHALL abort to IDLE and re-evaluate on the next e_rise; the aborted cycle SHALL NOT write RAM.
REQ-025 Reset out (exp_in[1]) SHALL go high on a rising edge of synchronised btn_reset and stay high for exactly RST_CYCLES cycles.
REQ-026 A new btn_reset edge during the reset pulse SHALL restart the count.
REQ-027 While the reset pulse is high, the FSM SHALL be forced to IDLE and no RAM write SHALL occur.
REQ-028 RAM contents SHALL be preserved across the reset pulse.
REQ-029 nmi (exp_in[0]) SHALL be debounced: btn_nmi must be stable high for DEB_CYCLES cycles to be accepted.
REQ-030 An accepted NMI press SHALL drive nmi high for 64 cycles, then low; no further pulse SHALL occur until btn_nmi is stable low for DEB_CYCLES.

Reset
REQ-031 While reset_n=0, exp_in SHALL be 11'h000, the FSM SHALL be in IDLE, and all counters and synchronisers SHALL be 0.
REQ-032 Release of reset_n SHALL take effect on the next clk_sys edge; RAM contents SHALL be undefined after power-up and SHALL NOT be cleared by reset_n.

Verification
REQ-033 Write then read: E period 32 clk; write 8'hA5 at 16'h5000 and 8'h3C at 16'h8FFF, then read both -> D=A5 and then 3C during RDHOLD, and D=00 outside RDHOLD.
REQ-034 Window boundaries: A=16'h4FFF and A=16'h9000 -> sel=0 and D=00; A=16'h5000 -> sel=1 one cycle after the address is applied.
REQ-035 Disable mid-read: drop enable while in RDHOLD -> D=00 and state IDLE next cycle; a following read at the same address still returns the prior data.
REQ-036 Reset pulse: btn_reset high for 3 cycles, with RST_CYCLES=100 -> exp_in[1] high for exactly 100 cycles starting 3 cycles after the edge; a write attempted during the pulse leaves RAM unchanged.
REQ-037 NMI debounce: with DEB_CYCLES=20, btn_nmi toggling every 5 cycles -> no pulse; btn_nmi held high for 25 cycles -> one 64-cycle nmi pulse.
REQ-038 Async reset: assert reset_n=0 in WR just before e_fall -> exp_in=000 immediately, no RAM write, and the FSM is in IDLE after release.

Source files
------------

// File: rtl/mc10_exp_ram.sv
// MC-10 expansion RAM pack: synchronises the asynchronous CPU bus strobe E, decodes the
// address window and serves RAM reads/writes, plus reset-pulse and debounced NMI buttons.
module mc10_exp_ram #(
  parameter logic [15:0] BASE_ADDR  = 16'h5000,
  parameter int unsigned SIZE_KB    = 16,
  parameter logic [15:0] RST_CYCLES = 16'd50000,
  parameter logic [15:0] DEB_CYCLES = 16'd10000
) (
  input  logic        clk_sys,
  input  logic        reset_n,
  input  logic [17:0] exp_out,
  input  logic [7:0]  cpu_dout,
  input  logic        enable,
  input  logic        btn_reset,
  input  logic        btn_nmi,
  output logic [10:0] exp_in
);

  localparam int unsigned DEPTH   = SIZE_KB * 1024;
  localparam int unsigned AW      = $clog2(DEPTH);
  localparam logic [16:0] WIN_END = 17'(BASE_ADDR) + 17'(DEPTH);

  typedef enum logic [1:0] {IDLE, RD, RDHOLD, WR} state_t;

  logic        rw;
  logic [15:0] addr;
  logic        e_raw;
  assign rw    = exp_out[17];
  assign addr  = exp_out[16:1];
  assign e_raw = exp_out[0];

  // [0] first flop, [1] synchronised level, [2] previous synchronised level for edges
  logic [2:0] e_sync, r_sync;
  logic [1:0] n_sync;
  logic       e_rise, e_fall, rst_rise;

  // NOTE: sequential state always uses non-blocking assignments so every flop samples
  // the pre-edge values of its neighbours, which is what makes the sync chains work.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      e_sync <= '0;
      r_sync <= '0;
      n_sync <= '0;
    end else begin
      e_sync <= {e_sync[1:0], e_raw};
      r_sync <= {r_sync[1:0], btn_reset};
      n_sync <= {n_sync[0], btn_nmi};
    end
  end

  assign e_rise   = e_sync[1] & ~e_sync[2];
  assign e_fall   = ~e_sync[1] & e_sync[2];
  assign rst_rise = r_sync[1] & ~r_sync[2];

  logic hit;
  assign hit = enable && ({1'b0, addr} >= 17'(BASE_ADDR)) && ({1'b0, addr} < WIN_END);

  // Reset pulse: reloading on every new edge restarts the pulse
  logic [15:0] rst_cnt;
  logic        rst_active;
  assign rst_active = (rst_cnt != 16'd0);

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n)                rst_cnt <= '0;
    else if (rst_rise)           rst_cnt <= RST_CYCLES;
    else if (rst_active)         rst_cnt <= rst_cnt - 16'd1;
  end

  // NMI: the accepted level only flips after the raw level differs for DEB_CYCLES cycles
  logic [15:0] deb_cnt;
  logic        nmi_level;
  logic [6:0]  nmi_cnt;
  logic        nmi_flip;
  assign nmi_flip = (n_sync[1] != nmi_level) && (deb_cnt == DEB_CYCLES - 16'd1);

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      deb_cnt   <= '0;
      nmi_level <= 1'b0;
      nmi_cnt   <= '0;
    end else begin
      if (n_sync[1] == nmi_level || nmi_flip) deb_cnt <= '0;
      else                                    deb_cnt <= deb_cnt + 16'd1;
      if (nmi_flip) nmi_level <= n_sync[1];
      if (nmi_flip && n_sync[1]) nmi_cnt <= 7'd64;
      else if (nmi_cnt != 7'd0)  nmi_cnt <= nmi_cnt - 7'd1;
    end
  end

  state_t        state, state_d;
  logic          latch, we, sel;
  logic [AW-1:0] addr_q;
  logic [7:0]    wdata_q, ram_q;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state;
    latch   = 1'b0;
    we      = 1'b0;
    if (rst_active) begin
      state_d = IDLE;
    end else begin
      unique case (state)
        IDLE: if (e_rise && hit) begin
          latch   = 1'b1;
          state_d = rw ? RD : WR;
        end
        RD:     state_d = (!enable || e_rise) ? IDLE : RDHOLD;
        RDHOLD: if (!enable || e_rise || e_fall) state_d = IDLE;
        WR: if (!enable || e_rise) begin
          state_d = IDLE;
        end else if (e_fall) begin
          we      = 1'b1;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      sel     <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state   <= state_d;
      sel     <= hit;
      wdata_q <= cpu_dout;
      if (latch) addr_q <= AW'(addr - BASE_ADDR);
    end
  end

  // NOTE: the RAM array has no reset so it maps onto block RAM; contents survive reset_n.
  logic [7:0] mem [DEPTH];
  always_ff @(posedge clk_sys) begin
    if (we) mem[addr_q] <= wdata_q;
    ram_q <= mem[addr_q];
  end

  // D is forced to zero outside RDHOLD so several cards can wire-OR onto the data bus
  logic [7:0] d_out;
  assign d_out  = (state == RDHOLD && enable) ? ram_q : 8'h00;
  assign exp_in = {d_out, sel, rst_active, nmi_cnt != 7'd0};

endmodule
